// File: rtl/icache_mem_arbiter.sv
// rtl/icache_mem_arbiter.sv - burst-holding round-robin arbiter for the icache refill memory port
// Optional saturating statistics counters are built when MEM_ARB_STATS_EN is defined.
module icache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4
`ifdef MEM_ARB_STATS_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic [DATA_WIDTH-1:0] mem_req_rdata,
  output logic [1:0]            grant
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_grants0,
  output logic [CNT_WIDTH-1:0]  stat_grants1,
  output logic [CNT_WIDTH-1:0]  stat_wait
`endif
);

  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            rr_q, rr_d;
  logic [1:0]      grant_q, grant_d;
  logic            owner_valid;
  logic            word_done;

  assign owner_valid = (state_q == GRANT1) ? req1_valid : req0_valid;
  assign word_done   = (state_q != IDLE) && owner_valid && mem_req_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (req0_valid && (!req1_valid || !rr_q)) begin
          state_d = GRANT0;
        end else if (req1_valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (word_done) begin
          beat_d = beat_q + 1'b1;
        end
        // A dropped valid ends the burst early; every release hands priority away.
        if (!owner_valid || (word_done && (beat_q == LAST_BEAT))) begin
          state_d = IDLE;
          beat_d  = '0;
          rr_d    = (state_q == GRANT0);
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == GRANT1, state_d == GRANT0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rr_q    <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  assign grant         = grant_q;
  assign mem_req_valid = (state_q != IDLE) && owner_valid;
  assign mem_req_addr  = (state_q == GRANT0) ? req0_addr :
                         (state_q == GRANT1) ? req1_addr : '0;
  assign req0_ready    = (state_q == GRANT0) && mem_req_ready;
  assign req1_ready    = (state_q == GRANT1) && mem_req_ready;
  assign req0_rdata    = mem_req_rdata;
  assign req1_rdata    = mem_req_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] grants0_q, grants1_q, wait_q;
  logic                 waiting;

  assign waiting = (req0_valid && !grant_q[0]) || (req1_valid && !grant_q[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      grants0_q <= '0;
      grants1_q <= '0;
      wait_q    <= '0;
    end else begin
      if ((state_q == IDLE) && (state_d == GRANT0) && (grants0_q != '1)) begin
        grants0_q <= grants0_q + 1'b1;
      end
      if ((state_q == IDLE) && (state_d == GRANT1) && (grants1_q != '1)) begin
        grants1_q <= grants1_q + 1'b1;
      end
      if (waiting && (wait_q != '1)) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end

  assign stat_grants0 = grants0_q;
  assign stat_grants1 = grants1_q;
  assign stat_wait    = wait_q;
`endif

endmodule
